score_keeper: RTL

//  Game-side score engine feeding seven_segment_display.score. Runs the round FSM
//  (IDLE/PLAYING/OVER), accrues survival points on a tick divider plus coin bonuses,

---
 rtl/score_pkg.sv | 17 +
 rtl/rise_edge.sv | 19 +
 rtl/score_keeper.sv | 129 ++++++++++++
 3 files changed

// File: rtl/score_pkg.sv
// Shared state encodings and default parameter values for the score engine.
package score_pkg;

  // Round FSM encoding; ST_BAD is never entered in normal operation.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PLAYING = 2'b01,
    ST_OVER    = 2'b10,
    ST_BAD     = 2'b11
  } state_e;

  localparam int DEF_SCORE_W     = 16;
  localparam int DEF_MAX_SCORE   = 9999;
  localparam int DEF_TICK_DIV    = 1000000;
  localparam int DEF_COIN_POINTS = 10;

endpackage

// File: rtl/rise_edge.sv
// Rising-edge detector: one-cycle pulse on the first clock that samples d high.
module rise_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);

  logic d_q;

  // History register holding last sampled value of d.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign pulse = d & ~d_q;

endmodule

// File: rtl/score_keeper.sv
// Score engine: round FSM, survival tick divider, coin bonus, saturating score,
// high-score tracking and a registered display bus.
module score_keeper
  import score_pkg::*;
#(
  parameter int SCORE_W     = DEF_SCORE_W,
  parameter int MAX_SCORE   = DEF_MAX_SCORE,
  parameter int TICK_DIV    = DEF_TICK_DIV,
  parameter int COIN_POINTS = DEF_COIN_POINTS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               coin,
  input  logic               collide,
  input  logic               pause,
  output logic [1:0]         state,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic               new_high,
  output logic [SCORE_W-1:0] display_score
);

  // A divider of 1 still needs a one-bit counter to stay legal.
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [SCORE_W:0]   MAX_EXT   = (SCORE_W + 1)'(MAX_SCORE);
  localparam logic [SCORE_W:0]   COIN_EXT  = (SCORE_W + 1)'(COIN_POINTS);
  localparam logic [SCORE_W:0]   ONE_EXT   = (SCORE_W + 1)'(1);

  logic start_ev, coin_ev, collide_ev;

  state_e              state_q, state_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [SCORE_W-1:0]  high_q, high_d;
  logic                new_high_q, new_high_d;
  logic [SCORE_W-1:0]  display_q, display_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [SCORE_W:0]    add_pts;
  logic [SCORE_W:0]    sum;

  rise_edge u_start_edge (.clk(clk), .reset(reset), .d(start),   .pulse(start_ev));
  rise_edge u_coin_edge  (.clk(clk), .reset(reset), .d(coin),    .pulse(coin_ev));
  rise_edge u_hit_edge   (.clk(clk), .reset(reset), .d(collide), .pulse(collide_ev));

  // Next-state logic: FSM transitions, point accrual and high-score capture.
  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    high_d     = high_q;
    new_high_d = new_high_q;
    tick_d     = tick_q;
    add_pts    = '0;
    sum        = '0;

    case (state_q)
      ST_IDLE: begin
        if (start_ev) begin
          state_d    = ST_PLAYING;
          score_d    = '0;
          tick_d     = '0;
          new_high_d = 1'b0;
        end
      end

      ST_PLAYING: begin
        // Collision ends the round and suppresses any points this cycle.
        if (collide_ev) begin
          state_d = ST_OVER;
          if (score_q > high_q) begin
            high_d     = score_q;
            new_high_d = 1'b1;
          end
        end else if (!pause) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            add_pts = ONE_EXT;
          end else begin
            tick_d = tick_q + 1'b1;
          end
          if (coin_ev) add_pts = add_pts + COIN_EXT;
          // One extra bit keeps the overflow visible before clamping.
          sum     = {1'b0, score_q} + add_pts;
          score_d = (sum > MAX_EXT) ? MAX_EXT[SCORE_W-1:0] : sum[SCORE_W-1:0];
        end
      end

      ST_OVER: begin
        if (start_ev) begin
          state_d    = ST_PLAYING;
          score_d    = '0;
          tick_d     = '0;
          new_high_d = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Display follows the post-edge values so it moves together with score.
    display_d = (state_d == ST_IDLE) ? high_d : score_d;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      score_q    <= '0;
      high_q     <= '0;
      new_high_q <= 1'b0;
      display_q  <= '0;
      tick_q     <= '0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      high_q     <= high_d;
      new_high_q <= new_high_d;
      display_q  <= display_d;
      tick_q     <= tick_d;
    end
  end

  assign state         = state_q;
  assign score         = score_q;
  assign high_score    = high_q;
  assign new_high      = new_high_q;
  assign display_score = display_q;

endmodule
